sc_frog_position_register: RTL and testbench



---
 rtl/sc_frog_position_register_pkg.sv | 18 +
 rtl/sc_frog_matrix_decoder.sv | 29 ++
 rtl/sc_frog_position_register.sv | 137 +++++++++++++
 tb/tb_sc_frog_position_register.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_frog_position_register_pkg.sv
// rtl/sc_frog_position_register_pkg.sv - shared constants for the frog position datapath
// Holds the shift-selection codes, default playfield geometry and index widths
// used by sc_frog_position_register and sc_frog_matrix_decoder.
package sc_frog_position_register_pkg;

  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  localparam int ROWS_DEF      = 8;
  localparam int COLS_DEF      = 8;
  localparam int START_COL_DEF = 3;
  localparam int CNT_W_DEF     = 8;

  localparam int ROW_W_DEF = $clog2(ROWS_DEF);
  localparam int COL_W_DEF = $clog2(COLS_DEF);

endpackage

// File: rtl/sc_frog_matrix_decoder.sv
// rtl/sc_frog_matrix_decoder.sv - combinational row/col to one-hot playfield bitmap
// Ports:
//   i_row    : row index, 0 = top
//   i_col    : column index, 0 = rightmost
//   o_matrix : ROWS*COLS bitmap, row r occupies bits [r*COLS +: COLS]; one bit set
module sc_frog_matrix_decoder
  import sc_frog_position_register_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [$clog2(ROWS)-1:0] i_row,
  input  logic [$clog2(COLS)-1:0] i_col,
  output logic [ROWS*COLS-1:0]    o_matrix
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  always_comb begin
    o_matrix = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        o_matrix[r*COLS + c] = (i_row == RW'(r)) && (i_col == CW'(c));
      end
    end
  end

endmodule

// File: rtl/sc_frog_position_register.sv
// rtl/sc_frog_position_register.sv - frog row/column register with move counter
// Ports:
//   SC_FROGPOSITION_CLOCK_50                    : system clock
//   SC_FROGPOSITION_RESET_InHigh                : asynchronous reset, active-high
//   SC_FROGPOSITION_clear_InLow                 : load start position, active-low
//   SC_FROGPOSITION_load0_InLow                 : move up one row, active-low
//   SC_FROGPOSITION_load1_InLow                 : move down one row, active-low
//   SC_FROGPOSITION_shiftselection_In           : 01 left, 10 right, else hold
//   SC_FROGPOSITION_matrix_Out                  : one-hot playfield bitmap
//   SC_FROGPOSITION_row_Out / col_Out           : current position
//   SC_FROGPOSITION_bottomsidecomparator_OutLow : 0 while on the bottom row
//   SC_FROGPOSITION_topreached_Out              : one-cycle pulse on entering row 0
//   SC_FROGPOSITION_moves_Out                   : saturating successful-move count
module sc_frog_position_register
  import sc_frog_position_register_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int START_COL = START_COL_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                    SC_FROGPOSITION_CLOCK_50,
  input  logic                    SC_FROGPOSITION_RESET_InHigh,
  input  logic                    SC_FROGPOSITION_clear_InLow,
  input  logic                    SC_FROGPOSITION_load0_InLow,
  input  logic                    SC_FROGPOSITION_load1_InLow,
  input  logic [1:0]              SC_FROGPOSITION_shiftselection_In,
  output logic [ROWS*COLS-1:0]    SC_FROGPOSITION_matrix_Out,
  output logic [$clog2(ROWS)-1:0] SC_FROGPOSITION_row_Out,
  output logic [$clog2(COLS)-1:0] SC_FROGPOSITION_col_Out,
  output logic                    SC_FROGPOSITION_bottomsidecomparator_OutLow,
  output logic                    SC_FROGPOSITION_topreached_Out,
  output logic [CNT_W-1:0]        SC_FROGPOSITION_moves_Out
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_LAST  = CW'(COLS - 1);
  localparam logic [CW-1:0]    COL_START = CW'(START_COL);
  localparam logic [CNT_W-1:0] MOVES_MAX = {CNT_W{1'b1}};

  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [CNT_W-1:0] r_moves;
  logic             r_top;

  logic [RW-1:0]    w_row_nxt;
  logic [CW-1:0]    w_col_nxt;
  logic [CNT_W-1:0] w_moves_nxt;
  logic             w_top_nxt;
  logic             w_moved;
  logic             w_clear;

  // Priority chain: only the highest-priority active command is considered,
  // and a blocked move (at an edge) still consumes the cycle without counting.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_top_nxt = 1'b0;
    w_moved   = 1'b0;
    w_clear   = 1'b0;
    if (!SC_FROGPOSITION_clear_InLow) begin
      w_clear   = 1'b1;
      w_row_nxt = ROW_LAST;
      w_col_nxt = COL_START;
    end else if (!SC_FROGPOSITION_load0_InLow) begin
      if (r_row != '0) begin
        w_row_nxt = r_row - RW'(1);
        w_moved   = 1'b1;
        // Pulse only on the 1->0 transition, never while parked at the top.
        w_top_nxt = (r_row == RW'(1));
      end
    end else if (!SC_FROGPOSITION_load1_InLow) begin
      if (r_row != ROW_LAST) begin
        w_row_nxt = r_row + RW'(1);
        w_moved   = 1'b1;
      end
    end else begin
      case (SC_FROGPOSITION_shiftselection_In)
        SHIFT_LEFT: begin
          if (r_col != COL_LAST) begin
            w_col_nxt = r_col + CW'(1);
            w_moved   = 1'b1;
          end
        end
        SHIFT_RIGHT: begin
          if (r_col != '0) begin
            w_col_nxt = r_col - CW'(1);
            w_moved   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_moves_nxt = r_moves;
    if (w_clear) begin
      w_moves_nxt = '0;
    end else if (w_moved && (r_moves != MOVES_MAX)) begin
      w_moves_nxt = r_moves + CNT_W'(1);
    end
  end

  always_ff @(posedge SC_FROGPOSITION_CLOCK_50 or posedge SC_FROGPOSITION_RESET_InHigh) begin
    if (SC_FROGPOSITION_RESET_InHigh) begin
      r_row   <= ROW_LAST;
      r_col   <= COL_START;
      r_moves <= '0;
      r_top   <= 1'b0;
    end else begin
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_moves <= w_moves_nxt;
      r_top   <= w_top_nxt;
    end
  end

  sc_frog_matrix_decoder #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_matrix_decoder (
    .i_row    (r_row),
    .i_col    (r_col),
    .o_matrix (SC_FROGPOSITION_matrix_Out)
  );

  assign SC_FROGPOSITION_row_Out                     = r_row;
  assign SC_FROGPOSITION_col_Out                     = r_col;
  assign SC_FROGPOSITION_bottomsidecomparator_OutLow = (r_row != ROW_LAST);
  assign SC_FROGPOSITION_topreached_Out              = r_top;
  assign SC_FROGPOSITION_moves_Out                   = r_moves;

endmodule

// File: tb/tb_sc_frog_position_register.sv
// tb/tb_sc_frog_position_register.sv - self-checking bench for sc_frog_position_register
module tb_sc_frog_position_register;

  logic        clk;
  logic        rst;
  logic        clear_n;
  logic        load0_n;
  logic        load1_n;
  logic [1:0]  shift;
  logic [63:0] matrix;
  logic [2:0]  row;
  logic [2:0]  col;
  logic        bottom_n;
  logic        top;
  logic [7:0]  moves;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  // Reference model: plain integers following the movement rules.
  int m_row   = 7;
  int m_col   = 3;
  int m_moves = 0;
  bit m_top   = 0;

  sc_frog_position_register dut (
    .SC_FROGPOSITION_CLOCK_50                    (clk),
    .SC_FROGPOSITION_RESET_InHigh                (rst),
    .SC_FROGPOSITION_clear_InLow                 (clear_n),
    .SC_FROGPOSITION_load0_InLow                 (load0_n),
    .SC_FROGPOSITION_load1_InLow                 (load1_n),
    .SC_FROGPOSITION_shiftselection_In           (shift),
    .SC_FROGPOSITION_matrix_Out                  (matrix),
    .SC_FROGPOSITION_row_Out                     (row),
    .SC_FROGPOSITION_col_Out                     (col),
    .SC_FROGPOSITION_bottomsidecomparator_OutLow (bottom_n),
    .SC_FROGPOSITION_topreached_Out              (top),
    .SC_FROGPOSITION_moves_Out                   (moves)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_row = 7; m_col = 3; m_moves = 0; m_top = 0;
    end else begin
      bit moved;
      moved = 0;
      m_top = 0;
      if (!clear_n) begin
        m_row = 7; m_col = 3; m_moves = 0;
      end else if (!load0_n) begin
        if (m_row > 0) begin
          if (m_row == 1) m_top = 1;
          m_row = m_row - 1; moved = 1;
        end
      end else if (!load1_n) begin
        if (m_row < 7) begin m_row = m_row + 1; moved = 1; end
      end else if (shift == 2'b01) begin
        if (m_col < 7) begin m_col = m_col + 1; moved = 1; end
      end else if (shift == 2'b10) begin
        if (m_col > 0) begin m_col = m_col - 1; moved = 1; end
      end
      if (moved && m_moves < 255) m_moves = m_moves + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic [63:0] exp_m;
      exp_m = 64'd1 << (m_row * 8 + m_col);
      chk("cyc_row", 64'(row), 64'(m_row));
      chk("cyc_col", 64'(col), 64'(m_col));
      chk("cyc_matrix", matrix, exp_m);
      chk("cyc_bottom_n", 64'(bottom_n), 64'(m_row != 7));
      chk("cyc_top", 64'(top), 64'(m_top));
      chk("cyc_moves", 64'(moves), 64'(m_moves));
      tests++;
      assert ($onehot(matrix)) else begin
        fails++;
        $display("FAIL onehot: matrix %0h", matrix);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_n = 1; load0_n = 1; load1_n = 1; shift = 2'b11;
  endtask

  task automatic pulse_load0(input int n);
    for (int i = 0; i < n; i++) begin
      load0_n = 0; cyc(); load0_n = 1;
    end
  endtask

  task automatic do_clear();
    clear_n = 0; cyc(); clear_n = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (3) cyc();
    rst = 0;
    check_en = 1;
    cyc();
    chk("reset_row", 64'(row), 64'd7);
    chk("reset_col", 64'(col), 64'd3);
    chk("reset_bit59", 64'(matrix[59]), 64'd1);
    chk("reset_bottom_n", 64'(bottom_n), 64'd0);
    chk("reset_moves", 64'(moves), 64'd0);

    // Up to the goal row, one pulse at a time with a gap cycle.
    for (int i = 0; i < 7; i++) begin
      load0_n = 0; cyc(); load0_n = 1;
      if (i == 6) chk("top_pulse", 64'(top), 64'd1);
      cyc();
      if (i == 6) chk("top_gone", 64'(top), 64'd0);
    end
    chk("up_row", 64'(row), 64'd0);
    chk("up_moves", 64'(moves), 64'd7);
    pulse_load0(1);
    chk("up8_row", 64'(row), 64'd0);
    chk("up8_moves", 64'(moves), 64'd7);
    chk("up8_top", 64'(top), 64'd0);

    // Column saturation both directions.
    do_clear();
    shift = 2'b01; repeat (6) cyc(); shift = 2'b11;
    chk("left_col", 64'(col), 64'd7);
    chk("left_moves", 64'(moves), 64'd4);
    shift = 2'b10; repeat (9) cyc(); shift = 2'b11;
    chk("right_col", 64'(col), 64'd0);
    chk("right_moves", 64'(moves), 64'd11);

    // Clear beats load0 and shift in the same cycle.
    pulse_load0(5);
    shift = 2'b01; repeat (5) cyc(); shift = 2'b11;
    chk("pre_clr_row", 64'(row), 64'd2);
    chk("pre_clr_col", 64'(col), 64'd5);
    clear_n = 0; load0_n = 0; shift = 2'b01; cyc(); idle();
    chk("clr_row", 64'(row), 64'd7);
    chk("clr_col", 64'(col), 64'd3);
    chk("clr_moves", 64'(moves), 64'd0);

    // load0 beats load1.
    pulse_load0(3);
    load0_n = 0; load1_n = 0; cyc(); idle();
    chk("prio_row", 64'(row), 64'd3);
    chk("prio_moves", 64'(moves), 64'd4);
    load1_n = 0; repeat (2) cyc(); idle();
    chk("down_row", 64'(row), 64'd5);

    // Down at the bottom row holds, then async reset between edges.
    do_clear();
    load1_n = 0; cyc(); idle();
    chk("bot_row", 64'(row), 64'd7);
    chk("bot_moves", 64'(moves), 64'd0);
    shift = 2'b01; repeat (3) cyc(); shift = 2'b11;
    chk("pre_rst_moves", 64'(moves), 64'd3);
    #2 rst = 1;
    #1;
    chk("arst_row", 64'(row), 64'd7);
    chk("arst_col", 64'(col), 64'd3);
    chk("arst_bit59", 64'(matrix[59]), 64'd1);
    chk("arst_moves", 64'(moves), 64'd0);
    chk("arst_top", 64'(top), 64'd0);
    cyc();
    rst = 0;
    cyc();

    // Move counter saturation.
    for (int i = 0; i < 300; i++) begin
      shift = (i % 2 == 0) ? 2'b01 : 2'b10;
      cyc();
    end
    shift = 2'b11;
    chk("sat_moves", 64'(moves), 64'd255);
    cyc();
    check_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
